serial_io_port: RTL and testbench

Memory-mapped UART peripheral on the CPU's I/O bus, acting as the device end of the CPU's port protocol. The CPU writes with `DI` and reads with `DO` at a decoded address. Writes to the data port are queued in a TX FIFO and serialised as 8N1 frames. Received frames are deserialised into a holding register that the CPU reads back through the same data port, with a status port for polling.

---
 rtl/serial_io_pkg.sv | 22 ++
 rtl/io_fifo.sv | 49 ++++
 rtl/serial_io_port.sv | 249 ++++++++++++++++++++++++
 tb/tb_serial_io_port.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/serial_io_pkg.sv
// Shared definitions for the memory-mapped UART port: register offsets,
// status bit positions and the line-state encoding used by both TX and RX.
package serial_io_pkg;

    localparam int OFS_DATA = 0;
    localparam int OFS_STAT = 1;

    localparam int ST_RX_VALID    = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_TX_OVERFLOW = 4;
    localparam int ST_FRAMING_ERR = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/io_fifo.sv
// Synchronous FIFO with array storage and a registered read port; pop_data
// is valid the cycle after a pop and holds until the next pop.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset_bar,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_reg;
    logic [AW:0]      rd_ptr_reg;
    logic             do_push;
    logic             do_pop;

    // One extra pointer bit distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) && (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
        if (do_pop) begin
            pop_data <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_io_port.sv
// UART peripheral on the CPU I/O bus: data/status port decode, TX FIFO with
// 8N1 serialiser, and a mid-bit sampling 8N1 receiver with sticky flags.
module serial_io_port
    import serial_io_pkg::*;
#(
    parameter int BASE_ADDR = 136,
    parameter int CLK_DIV   = 104,
    parameter int TX_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        reset_bar,
    input  logic [15:0] addr,
    input  logic [15:0] io_in,
    input  logic        DI,
    input  logic        DO,
    output logic [15:0] io_out,
    output logic        io_oe,
    input  logic        rx,
    output logic        tx
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLK_DIV / 2 - 1);

    logic sel_data, sel_stat, data_rd, stat_rd, data_wr;
    logic fifo_push, fifo_pop, fifo_full, fifo_empty, tx_idle;
    logic [7:0] fifo_data;
    logic [15:0] status;
    logic unused_upper;

    uart_state_t tx_state_reg, tx_state_next;
    logic [CW-1:0] tx_cnt_reg, tx_cnt_next;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic tx_reg, tx_next;

    uart_state_t rx_state_reg, rx_state_next;
    logic [CW-1:0] rx_cnt_reg, rx_cnt_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic rx_brk_reg, rx_brk_next;
    logic rx_meta_reg, rx_sync_reg, rx_prev_reg;
    logic rx_load, rx_ferr;

    logic [7:0] rx_byte_reg;
    logic rx_valid_reg, rx_overrun_reg, tx_overflow_reg, framing_err_reg;

    assign sel_data  = (addr == 16'(BASE_ADDR + OFS_DATA));
    assign sel_stat  = (addr == 16'(BASE_ADDR + OFS_STAT));
    assign data_rd   = DO & sel_data;
    assign stat_rd   = DO & sel_stat;
    assign data_wr   = DI & sel_data;
    assign fifo_push = data_wr & ~fifo_full;
    assign tx_idle   = fifo_empty & (tx_state_reg == IDLE);
    assign io_oe     = DO & (sel_data | sel_stat);
    assign tx        = tx_reg;
    assign unused_upper = ^io_in[15:8];

    always_comb begin
        status = '0;
        status[ST_RX_VALID]    = rx_valid_reg;
        status[ST_TX_FULL]     = fifo_full;
        status[ST_TX_IDLE]     = tx_idle;
        status[ST_RX_OVERRUN]  = rx_overrun_reg;
        status[ST_TX_OVERFLOW] = tx_overflow_reg;
        status[ST_FRAMING_ERR] = framing_err_reg;
        io_out = '0;
        if (data_rd)      io_out = {8'h00, rx_byte_reg};
        else if (stat_rd) io_out = status;
    end

    io_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset_bar (reset_bar),
        .push      (fifo_push),
        .push_data (io_in[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The popped byte is only needed when START ends, which hides the FIFO read latency.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_next       = tx_reg;
        fifo_pop      = 1'b0;
        case (tx_state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop      = 1'b1;
                    tx_state_next = START;
                    tx_cnt_next   = BIT_LAST;
                    tx_next       = 1'b0;
                end
            end
            START: begin
                if (tx_cnt_reg == '0) begin
                    tx_state_next = DATA;
                    tx_cnt_next   = BIT_LAST;
                    tx_bit_next   = 3'd0;
                    tx_shift_next = fifo_data;
                    tx_next       = fifo_data[0];
                end else begin
                    tx_cnt_next = tx_cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (tx_cnt_reg == '0) begin
                    tx_cnt_next = BIT_LAST;
                    if (tx_bit_reg == 3'd7) begin
                        tx_state_next = STOP;
                        tx_next       = 1'b1;
                    end else begin
                        tx_bit_next   = tx_bit_reg + 3'd1;
                        tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                        tx_next       = tx_shift_reg[1];
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (tx_cnt_reg == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop      = 1'b1;
                        tx_state_next = START;
                        tx_cnt_next   = BIT_LAST;
                        tx_next       = 1'b0;
                    end else begin
                        tx_state_next = IDLE;
                    end
                end else begin
                    tx_cnt_next = tx_cnt_reg - 1'b1;
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    // rx_brk_reg marks a framing error still waiting for the line to go high.
    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_brk_next   = rx_brk_reg;
        rx_load       = 1'b0;
        rx_ferr       = 1'b0;
        case (rx_state_reg)
            IDLE: begin
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_state_next = START;
                    rx_cnt_next   = HALF_LAST;
                end
            end
            START: begin
                if (rx_cnt_reg == '0) begin
                    if (rx_sync_reg) begin
                        rx_state_next = IDLE;
                    end else begin
                        rx_state_next = DATA;
                        rx_cnt_next   = BIT_LAST;
                        rx_bit_next   = 3'd0;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - 1'b1;
                end
            end
            DATA: begin
                if (rx_cnt_reg == '0) begin
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_cnt_next   = BIT_LAST;
                    if (rx_bit_reg == 3'd7) rx_state_next = STOP;
                    else                    rx_bit_next   = rx_bit_reg + 3'd1;
                end else begin
                    rx_cnt_next = rx_cnt_reg - 1'b1;
                end
            end
            STOP: begin
                if (rx_brk_reg) begin
                    if (rx_sync_reg) begin
                        rx_brk_next   = 1'b0;
                        rx_state_next = IDLE;
                    end
                end else if (rx_cnt_reg == '0) begin
                    if (rx_sync_reg) begin
                        rx_load       = 1'b1;
                        rx_state_next = IDLE;
                    end else begin
                        rx_ferr     = 1'b1;
                        rx_brk_next = 1'b1;
                    end
                end else begin
                    rx_cnt_next = rx_cnt_reg - 1'b1;
                end
            end
            default: rx_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_bar) begin
        if (!reset_bar) begin
            tx_state_reg    <= IDLE;
            tx_cnt_reg      <= '0;
            tx_bit_reg      <= '0;
            tx_shift_reg    <= '0;
            tx_reg          <= 1'b1;
            rx_state_reg    <= IDLE;
            rx_cnt_reg      <= '0;
            rx_bit_reg      <= '0;
            rx_shift_reg    <= '0;
            rx_brk_reg      <= 1'b0;
            rx_meta_reg     <= 1'b1;
            rx_sync_reg     <= 1'b1;
            rx_prev_reg     <= 1'b1;
            rx_byte_reg     <= '0;
            rx_valid_reg    <= 1'b0;
            rx_overrun_reg  <= 1'b0;
            tx_overflow_reg <= 1'b0;
            framing_err_reg <= 1'b0;
        end else begin
            tx_state_reg    <= tx_state_next;
            tx_cnt_reg      <= tx_cnt_next;
            tx_bit_reg      <= tx_bit_next;
            tx_shift_reg    <= tx_shift_next;
            tx_reg          <= tx_next;
            rx_state_reg    <= rx_state_next;
            rx_cnt_reg      <= rx_cnt_next;
            rx_bit_reg      <= rx_bit_next;
            rx_shift_reg    <= rx_shift_next;
            rx_brk_reg      <= rx_brk_next;
            rx_meta_reg     <= rx;
            rx_sync_reg     <= rx_meta_reg;
            rx_prev_reg     <= rx_sync_reg;
            if (rx_load) rx_byte_reg <= rx_shift_reg;
            // A same-cycle set always beats a read-clear.
            rx_valid_reg    <= rx_load | (rx_valid_reg & ~data_rd);
            rx_overrun_reg  <= (rx_load & rx_valid_reg & ~data_rd) | (rx_overrun_reg & ~stat_rd);
            tx_overflow_reg <= (data_wr & fifo_full) | (tx_overflow_reg & ~stat_rd);
            framing_err_reg <= rx_ferr | (framing_err_reg & ~stat_rd);
        end
    end

endmodule

// File: tb/tb_serial_io_port.sv
// Directed bench for serial_io_port with CLK_DIV=4 and TX_DEPTH=4; tx is
// logged every cycle so whole frames can be compared against hand-built patterns.
module tb_serial_io_port;

    localparam int DIV  = 4;
    localparam int DATA_ADDR = 136;
    localparam int STAT_ADDR = 137;

    logic        clk = 1'b0;
    logic        reset_bar = 1'b0;
    logic [15:0] addr = '0;
    logic [15:0] io_in = '0;
    logic        DI = 1'b0;
    logic        DO = 1'b0;
    logic [15:0] io_out;
    logic        io_oe;
    logic        rx = 1'b1;
    logic        tx;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic tx_log [0:8191];

    serial_io_port #(.BASE_ADDR(136), .CLK_DIV(DIV), .TX_DEPTH(4)) dut (
        .clk       (clk),
        .reset_bar (reset_bar),
        .addr      (addr),
        .io_in     (io_in),
        .DI        (DI),
        .DO        (DO),
        .io_out    (io_out),
        .io_oe     (io_oe),
        .rx        (rx),
        .tx        (tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (cyc < 8192) tx_log[cyc] = tx;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input int a, input logic [15:0] d);
        addr = 16'(a); io_in = d; DI = 1'b1;
        @(negedge clk);
        DI = 1'b0;
        $display("WR addr=%0d data=%h", a, d);
    endtask

    task automatic bus_read(input int a, output logic [15:0] d, output logic oe);
        addr = 16'(a); DO = 1'b1;
        #1;
        d = io_out; oe = io_oe;
        @(negedge clk);
        DO = 1'b0;
        $display("RD addr=%0d data=%h oe=%b", a, d, oe);
    endtask

    task automatic read_chk(input string tag, input int a, input logic [15:0] exp);
        logic [15:0] d;
        logic oe;
        bus_read(a, d, oe);
        chk(tag, {47'd0, oe, d}, {47'd0, 1'b1, exp});
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (DIV) @(negedge clk);
        end
        rx = 1'b1;
        $display("RX frame byte=%h stop=%b", b, stop);
    endtask

    // start = log index of the first start-bit sample; the sample before it must be high.
    task automatic check_frame(input string tag, input int start, input logic [7:0] b);
        logic [40:0] got, exp;
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        exp[0] = 1'b1;
        got[0] = tx_log[start-1];
        for (int i = 1; i <= 40; i++) begin
            exp[i] = fr[(i-1)/DIV];
            got[i] = tx_log[start-1+i];
        end
        chk(tag, 64'(got), 64'(exp));
    endtask

    initial begin
        int c0;
        logic [39:0] idle_got;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_oe", 64'(io_oe), 64'd0);
        chk("rst_out", 64'(io_out), 64'd0);
        reset_bar = 1'b1;
        @(negedge clk);
        read_chk("rst_stat", STAT_ADDR, 16'h0004);

        // Single frame, upper byte ignored
        c0 = cyc;
        bus_write(DATA_ADDR, 16'hAB41);
        repeat (44) @(negedge clk);
        check_frame("frame_41", c0 + 2, 8'h41);
        read_chk("idle_after_41", STAT_ADDR, 16'h0004);

        // Back-to-back writes overflowing the 4-deep FIFO
        c0 = cyc;
        for (int d = 1; d <= 6; d++) begin
            addr = 16'(DATA_ADDR); io_in = 16'(d); DI = 1'b1;
            @(negedge clk);
            $display("WR addr=%0d data=%h", DATA_ADDR, 16'(d));
        end
        DI = 1'b0;
        repeat (40) @(negedge clk);
        read_chk("ovf_stat", STAT_ADDR, 16'h0010);
        read_chk("ovf_clear", STAT_ADDR, 16'h0000);
        repeat (200) @(negedge clk);
        for (int f = 0; f < 5; f++) begin
            check_frame($sformatf("burst_frame%0d", f), c0 + 2 + 40*f, 8'(f + 1));
        end
        for (int i = 0; i < 40; i++) idle_got[i] = tx_log[c0 + 202 + i];
        chk("no_sixth_frame", 64'(idle_got), 64'h00_FFFF_FFFFFF);
        read_chk("burst_idle", STAT_ADDR, 16'h0004);

        // RX single frame
        send_rx(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        read_chk("rx5a_stat", STAT_ADDR, 16'h0005);
        read_chk("rx5a_data", DATA_ADDR, 16'h005A);
        read_chk("rx5a_clear", STAT_ADDR, 16'h0004);

        // RX overrun, TX kept busy so tx_idle reads 0 on the first poll
        send_rx(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        bus_write(DATA_ADDR, 16'h0000);
        bus_write(DATA_ADDR, 16'h00FF);
        send_rx(8'h33, 1'b1);
        repeat (4) @(negedge clk);
        read_chk("ovr_stat", STAT_ADDR, 16'h0009);
        read_chk("ovr_data", DATA_ADDR, 16'h0033);
        repeat (40) @(negedge clk);
        read_chk("ovr_clear", STAT_ADDR, 16'h0004);

        // Framing error: byte discarded, flag sticky until status read
        send_rx(8'hC3, 1'b0);
        repeat (4) @(negedge clk);
        read_chk("ferr_stat", STAT_ADDR, 16'h0024);
        read_chk("ferr_data", DATA_ADDR, 16'h0033);
        read_chk("ferr_clear", STAT_ADDR, 16'h0004);

        // One-cycle glitch is a false start
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);
        read_chk("glitch_stat", STAT_ADDR, 16'h0004);

        // Reset mid-frame
        bus_write(DATA_ADDR, 16'h0055);
        repeat (2) @(negedge clk);
        chk("pre_rst_tx_low", 64'(tx), 64'd0);
        #2 reset_bar = 1'b0;
        #1;
        chk("async_rst_tx", 64'(tx), 64'd1);
        chk("async_rst_oe", 64'(io_oe), 64'd0);
        @(negedge clk);
        reset_bar = 1'b1;
        @(negedge clk);
        read_chk("post_rst_stat", STAT_ADDR, 16'h0004);
        read_chk("post_rst_data", DATA_ADDR, 16'h0000);
        repeat (50) @(negedge clk);
        chk("post_rst_tx_quiet", 64'(tx), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
